// File: rtl/trace_stream_receiver.sv
// Trace stream receiver: unpacks AXI-Stream trace beats, rebuilds timestamps, buffers them.
// Define TRACE_RX_TLAST_CHECK_EN to enable per-frame beat counting and tlast_error.
module trace_stream_receiver #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int RX_FIFO_DEPTH_LOG2 = 1,
  parameter int XLEN = 32,
  parameter int RISC_V_INSTRUCTION_WIDTH = 32,
  parameter int NO_OF_PERFORMANCE_EVENTS = 4,
  parameter int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8,
  parameter int CLK_COUNTER_WIDTH = 16,
  parameter logic [RISC_V_INSTRUCTION_WIDTH-1:0] WFI_INSTRUCTION = 32'h10500073,
  parameter int AXI_DATA_WIDTH = NO_OF_PERFORMANCE_EVENTS *
    PERFORMANCE_EVENT_MOD_COUNTER_WIDTH + NO_OF_PERFORMANCE_EVENTS +
    XLEN + CLK_COUNTER_WIDTH + RISC_V_INSTRUCTION_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic S_AXIS_tvalid,
  output logic S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic S_AXIS_tlast,
  input  logic [31:0] tlast_interval,
  input  logic clear,
  output logic out_valid,
  input  logic out_ready,
  output logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [TIMESTAMP_WIDTH-1:0] out_timestamp,
  output logic [NO_OF_PERFORMANCE_EVENTS-1:0] out_overflow_map,
  output logic [NO_OF_PERFORMANCE_EVENTS*PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0] out_counters,
  output logic out_last,
  output logic [31:0] pkt_count,
  output logic tlast_error,
  output logic stopped
);

  localparam int IW = RISC_V_INSTRUCTION_WIDTH;
  localparam int NE = NO_OF_PERFORMANCE_EVENTS;
  localparam int CTRW = NE * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;
  localparam int PC_LSB = CTRW + NE;
  localparam int DT_LSB = PC_LSB + XLEN;
  localparam int IN_LSB = AXI_DATA_WIDTH - IW;
  localparam int AW = RX_FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, STREAM, STOPPED} state_t;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [TIMESTAMP_WIDTH-1:0] ts;
    logic [NE-1:0] ovf;
    logic [CTRW-1:0] ctr;
    logic last;
  } entry_t;

  state_t state_q, state_d;
  logic rdy_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d;
  logic [31:0] pkt_q, pkt_d;
  entry_t mem_q [DEPTH];
  entry_t in_e, head;
  logic push, pop, full, is_wfi;

  always_comb begin
    in_e.instr = S_AXIS_tdata[IN_LSB +: IW];
    in_e.pc = S_AXIS_tdata[PC_LSB +: XLEN];
    in_e.ovf = S_AXIS_tdata[CTRW +: NE];
    in_e.ctr = S_AXIS_tdata[0 +: CTRW];
    in_e.last = S_AXIS_tlast;
    in_e.ts = ts_q + TIMESTAMP_WIDTH'(S_AXIS_tdata[DT_LSB +: CLK_COUNTER_WIDTH]);
    is_wfi = in_e.instr == WFI_INSTRUCTION;
  end

  // rdy_q holds tready low until the first edge after reset is released
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    S_AXIS_tready = rdy_q & ~full & (state_q != STOPPED);
    out_valid = cnt_q != '0;
    push = S_AXIS_tvalid & S_AXIS_tready & ~clear;
    pop = out_valid & out_ready & ~clear;
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    ts_d = ts_q;
    pkt_d = pkt_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    if (clear) begin
      state_d = IDLE;
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
      ts_d = '0;
      pkt_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + AW'(1);
        ts_d = in_e.ts;
        pkt_d = pkt_q + 32'd1;
        if (state_q == IDLE)
          state_d = STREAM;
        else if (state_q == STREAM && S_AXIS_tlast && is_wfi)
          state_d = STOPPED;
      end
      if (pop) rd_d = rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ts_q <= '0;
      pkt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rdy_q <= 1'b1;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ts_q <= ts_d;
      pkt_q <= pkt_d;
      if (push) mem_q[wr_q] <= in_e;
    end
  end

  assign head = mem_q[rd_q];
  assign out_instr = head.instr;
  assign out_pc = head.pc;
  assign out_timestamp = head.ts;
  assign out_overflow_map = head.ovf;
  assign out_counters = head.ctr;
  assign out_last = head.last;
  assign pkt_count = pkt_q;
  assign stopped = state_q == STOPPED;

`ifdef TRACE_RX_TLAST_CHECK_EN
  logic [31:0] fcnt_q, fcnt_d, fnext;
  logic err_q, err_d;

  // fnext is the 1-based position of the current beat within its frame
  always_comb begin
    fnext = fcnt_q + 32'd1;
    fcnt_d = fcnt_q;
    err_d = err_q;
    if (clear) begin
      fcnt_d = '0;
      err_d = 1'b0;
    end else if (push) begin
      if (S_AXIS_tlast) begin
        fcnt_d = '0;
        if (tlast_interval != '0 && fnext < tlast_interval && !is_wfi)
          err_d = 1'b1;
      end else begin
        fcnt_d = fnext;
        if (tlast_interval != '0 && fnext == tlast_interval)
          err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      err_q <= err_d;
    end
  end

  assign tlast_error = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = ^tlast_interval;
  assign tlast_error = 1'b0;
`endif

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Scoreboard bench for trace_stream_receiver: reference model feeds a queue,
// a separate monitor pops and compares every delivered entry.
module tb_trace_stream_receiver;

  localparam logic [31:0] WFI = 32'h10500073;
  localparam int DEPTH = 2;
`ifdef TRACE_RX_TLAST_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] ts;
    logic [3:0] ovf;
    logic [31:0] ctr;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic S_AXIS_tvalid = 1'b0;
  logic S_AXIS_tready;
  logic [115:0] S_AXIS_tdata = '0;
  logic S_AXIS_tlast = 1'b0;
  logic [31:0] tlast_interval = '0;
  logic clear = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [63:0] out_timestamp;
  logic [3:0] out_overflow_map;
  logic [31:0] out_counters;
  logic out_last;
  logic [31:0] pkt_count;
  logic tlast_error;
  logic stopped;

  trace_stream_receiver dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .tlast_interval(tlast_interval), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_timestamp(out_timestamp), .out_overflow_map(out_overflow_map),
    .out_counters(out_counters), .out_last(out_last),
    .pkt_count(pkt_count), .tlast_error(tlast_error), .stopped(stopped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state, describing the block after the coming edge
  int occ = 0;
  int st_m = 0;
  bit rdy_m = 0;
  bit err_m = 0;
  logic [63:0] ts_m = '0;
  logic [31:0] pkt_m = '0;
  logic [31:0] fcnt_m = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tready", 64'(S_AXIS_tready), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_pkt_count", 64'(pkt_count), 0);
      chk("rst_stopped", 64'(stopped), 0);
      chk("rst_tlast_error", 64'(tlast_error), 0);
      chk("rst_out_pc", 64'(out_pc), 0);
      chk("rst_out_ts", out_timestamp, 0);
      occ = 0; st_m = 0; rdy_m = 0; err_m = 0;
      ts_m = '0; pkt_m = '0; fcnt_m = '0;
      exp_q.delete();
    end else begin
      bit push, pop, exp_rdy;
      exp_rdy = rdy_m && occ < DEPTH && st_m != 2;
      chk("tready", 64'(S_AXIS_tready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(occ != 0));
      chk("pkt_count", 64'(pkt_count), 64'(pkt_m));
      chk("stopped", 64'(stopped), 64'(st_m == 2));
      chk("tlast_error", 64'(tlast_error), 64'(err_m));
      push = S_AXIS_tvalid && S_AXIS_tready && !clear;
      pop = out_valid && out_ready && !clear;
      if (clear) begin
        occ = 0; st_m = 0; err_m = 0;
        ts_m = '0; pkt_m = '0; fcnt_m = '0;
        exp_q.delete();
      end else begin
        if (push) begin
          exp_t e;
          logic [31:0] pos;
          e.instr = S_AXIS_tdata[115:84];
          e.pc = S_AXIS_tdata[67:36];
          e.ovf = S_AXIS_tdata[35:32];
          e.ctr = S_AXIS_tdata[31:0];
          e.last = S_AXIS_tlast;
          ts_m = ts_m + 64'(S_AXIS_tdata[83:68]);
          e.ts = ts_m;
          exp_q.push_back(e);
          pkt_m = pkt_m + 1;
          if (st_m == 0) st_m = 1;
          else if (st_m == 1 && e.last && e.instr == WFI) st_m = 2;
          pos = fcnt_m + 1;
          if (CHK_EN) begin
            if (e.last) begin
              if (tlast_interval != 0 && pos < tlast_interval && e.instr != WFI) err_m = 1;
              fcnt_m = 0;
            end else begin
              if (tlast_interval != 0 && pos == tlast_interval) err_m = 1;
              fcnt_m = pos;
            end
          end
        end
        occ = occ + int'(push) - int'(pop);
      end
      rdy_m = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_instr", 64'(out_instr), 64'(e.instr));
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_timestamp", out_timestamp, e.ts);
        chk("out_overflow_map", 64'(out_overflow_map), 64'(e.ovf));
        chk("out_counters", 64'(out_counters), 64'(e.ctr));
        chk("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [15:0] dt, input logic last);
    bit ok;
    int n;
    S_AXIS_tdata = {ins, dt, pc, 4'($urandom), 32'($urandom)};
    S_AXIS_tlast = last;
    S_AXIS_tvalid = 1'b1;
    ok = 0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = S_AXIS_tready;
      n++;
    end
    tick();
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast = 1'b0;
    chk("send_accept", 64'(ok), 1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    send(32'h00000013, 32'h80000000, 16'd5, 1'b0);
    tick();
    chk("single_pkt_count", 64'(pkt_count), 1);

    pulse_clear();
    send(32'h00000013, 32'h80000004, 16'd1, 1'b0);
    send(32'h00000013, 32'h80000008, 16'd1, 1'b0);
    send(32'h00000013, 32'h8000000c, 16'd7, 1'b0);
    repeat (2) tick();

    pulse_clear();
    out_ready = 1'b0;
    fork
      begin
        send(32'h00000013, 32'h100, 16'd2, 1'b0);
        send(32'h00000013, 32'h104, 16'd3, 1'b0);
        send(32'h00000013, 32'h108, 16'd4, 1'b0);
      end
      begin
        repeat (6) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    join
    out_ready = 1'b1;
    repeat (3) tick();

    pulse_clear();
    out_ready = 1'b0;
    send(32'h00000013, 32'h200, 16'd1, 1'b0);
    send(WFI, 32'h204, 16'd1, 1'b1);
    repeat (3) tick();
    chk("wfi_stopped", 64'(stopped), 1);
    out_ready = 1'b1;
    repeat (4) tick();
    pulse_clear();
    send(32'h00000013, 32'h300, 16'd3, 1'b0);
    tick();

    tlast_interval = 32'd4;
    pulse_clear();
    for (int i = 0; i < 4; i++) send(32'h00000033, 32'h400 + 32'(i*4), 16'd1, 1'b0);
    tick();
    chk("tlast_err_no_tlast", 64'(tlast_error), 64'(CHK_EN));
    pulse_clear();
    for (int i = 0; i < 4; i++) send(32'h00000033, 32'h500 + 32'(i*4), 16'd1, i == 3);
    tick();
    chk("tlast_err_on_time", 64'(tlast_error), 0);

    pulse_clear();
    for (int i = 0; i < 600; i++) begin
      S_AXIS_tvalid = ($urandom % 3) != 0;
      S_AXIS_tlast = ($urandom % 4) == 0;
      S_AXIS_tdata = {(($urandom % 10) == 0) ? WFI : 32'($urandom),
                      16'($urandom), 32'($urandom), 4'($urandom), 32'($urandom)};
      out_ready = ($urandom % 3) != 0;
      clear = (($urandom % 60) == 0) || (stopped && ($urandom % 6) == 0);
      if (clear) tlast_interval = $urandom % 6;
      tick();
    end
    S_AXIS_tvalid = 1'b0;
    clear = 1'b0;

    pulse_clear();
    out_ready = 1'b0;
    send(32'h00000013, 32'h600, 16'd9, 1'b0);
    send(32'h00000013, 32'h604, 16'd9, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_pkt_count", 64'(pkt_count), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    send(32'h00000013, 32'h700, 16'd4, 1'b0);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    tick();
    chk("drain_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
